onchip_mem_arbiter: RTL
=======================

// Module: onchip_mem_arbiter
// PURPOSE
//  Two-requester round-robin arbiter in front of the single-port on-chip RAM (1024 x 32, byte enables).
//  Lets two Avalon-MM style masters (e.g. a datapath FSM and a debug/init engine) share one RAM port.
//  Sits between the masters and the RAM instance; the RAM's registered address gives 1-cycle read latency.
// PARAMETERS
//  ADDR_W  10  word-address width (1024 words)
//  DATA_W  32  data width; BE_W = DATA_W/8 byte enables
// PORTS
//  clk              in   1       clock; all logic on rising edge
//  reset            in   1       synchronous, active-high reset
//  mN_address       in   ADDR_W  master N word address (N = 0,1)
//  mN_byteenable    in   BE_W    master N byte enables (writes only; reads return full word)
//  mN_read          in   1       master N read request
//  mN_write         in   1       master N write request
//  mN_writedata     in   DATA_W  master N write data
//  mN_waitrequest   out  1       1 = request not accepted this cycle; master holds its request stable
//  mN_readdata      out  DATA_W  read data; valid only when mN_readdatavalid = 1
//  mN_readdatavalid out  1       one-cycle pulse, one per accepted read
//  mem_address      out  ADDR_W  to RAM address
//  mem_byteenable   out  BE_W    to RAM byteenable
//  mem_chipselect   out  1       to RAM chipselect
//  mem_write        out  1       to RAM write
//  mem_writedata    out  DATA_W  to RAM writedata
//  mem_clken        out  1       to RAM clken; constant 1
//  mem_readdata     in   DATA_W  from RAM readdata (unregistered q, valid the cycle after the address)
// BEHAVIOUR
//  - reqN = mN_read | mN_write. Both set on one master is illegal; write wins, read ignored.
//  - Grant (combinational, same cycle): one reqN -> grant N; both -> grant != last_grant; none -> no grant.
//  - mN_waitrequest = reqN & ~grantN. An idle master sees waitrequest 0.
//  - Accept = reqN & grantN. Accepted request drives mem_* the same cycle, combinationally from master N.
//    mem_chipselect = any accept; mem_write = accepted write; no accept -> mem_chipselect = 0,
//    mem_write = 0, address/data don't-care.
//  - last_grant register updates only on an accept; holds otherwise.
//  - Read latency exactly 1: read accepted in cycle T -> mN_readdatavalid = 1 in T+1,
//    mN_readdata = mem_readdata in T+1. Tracked by a registered rd_pending flag + rd_tag (master id).
//    mN_readdata may equal mem_readdata at all times; only readdatavalid qualifies it.
//  - Write accepted in cycle T is committed at the T->T+1 edge; a read of the same address accepted
//    in T+1 returns the new data.
//  - Throughput: one access per cycle; back-to-back accesses by the same or alternating masters allowed.
//  - Under continuous contention grants alternate 0,1,0,1...; a waiting master waits at most 1 cycle.
//  - Reset (sync, while reset = 1): last_grant = 1 (master 0 wins first contention), rd_pending = 0,
//    both readdatavalid = 0, both waitrequest = 1, mem_chipselect = 0, mem_write = 0, mem_clken = 1.
//  - Reset mid-operation: a read accepted in the cycle before reset produces no readdatavalid;
//    a write accepted in a cycle with reset = 1 never happens (no accept during reset).
//  - Out-of-range address impossible (ADDR_W matches depth); no error response.
// STRUCTURE
//  - Package onchip_mem_arb_pkg: ADDR_W/DATA_W defaults; localparam M0 = 1'b0, M1 = 1'b1 master ids.
//  - Sub-module rr_arbiter_2: 2-way round-robin with req[1:0] in, grant[1:0] out, accept-gated
//    last_grant register, sync reset. Top level holds the muxes and the read-return tracker.
// TESTING
//  - Read after reset: m0_read @0x005 (RAM preloaded 0xDEADBEEF) -> waitrequest 0;
//    m0_readdatavalid the next cycle with 0xDEADBEEF; m1 sees no readdatavalid.
//  - Contention: m0 and m1 both write every cycle for 4 cycles -> accepts alternate m0,m1,m0,m1;
//    each master's waitrequest is high on alternate cycles.
//  - Byte write: m1 writes 0x11223344 be=4'b0101 over 0xAABBCCDD @0x3FF, then reads it back
//    -> 0xAA22CC44 with 1-cycle latency.
//  - Write-then-read: m0 writes 0x12345678 @0x010 in T; m1 reads 0x010 in T+1 -> m1_readdata 0x12345678 in T+2.
//  - Reset mid-read: m1 read accepted in T, reset = 1 in T+1 -> m1_readdatavalid stays 0;
//    first contention after reset is granted to m0.
//  - Illegal read+write on m0 @0x020 with data 0x0F0F0F0F -> write performed, no readdatavalid.

Source files
------------

// File: rtl/onchip_mem_arb_pkg.sv
// Shared constants for the two-master on-chip RAM arbiter.
// Master ids double as the round-robin last_grant encoding.
package onchip_mem_arb_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   // A read and a write on the same master in one cycle is treated as a write.
   function automatic logic is_read_only(input logic read, input logic write);
      return read & ~write;
   endfunction

endpackage

// File: rtl/onchip_mem_arbiter_rr.sv
// Two-way round-robin arbiter: combinational grant, last_grant register updated only on accept.
// No grant is issued while reset is high.
module rr_arbiter_2
   import onchip_mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   logic last_grant;

   // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      grant = 2'b00;
      if (!reset) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == M1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= M1;
      end else if (|grant) begin
         last_grant <= grant[1] ? M1 : M0;
      end
   end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port RAM (registered address, 1-cycle read latency) between two Avalon-MM masters.
// Accepted requests drive the RAM combinationally; a pending flag plus tag routes read data back.
module onchip_mem_arbiter
   import onchip_mem_arb_pkg::*;
#(
   parameter  int ADDR_W = DEF_ADDR_W,
   parameter  int DATA_W = DEF_DATA_W,
   localparam int BE_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,

   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,

   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,

   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);

   logic [1:0] req;
   logic [1:0] grant;
   logic       sel;
   logic       rd_accept;
   logic       rd_pending;
   logic       rd_tag;

   assign req = {m1_read | m1_write, m0_read | m0_write};

   rr_arbiter_2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .grant (grant)
   );

   assign sel = grant[1] ? M1 : M0;

   // Waitrequest is forced high during reset because the arbiter grants nothing then.
   assign m0_waitrequest = reset | (req[0] & ~grant[0]);
   assign m1_waitrequest = reset | (req[1] & ~grant[1]);

   assign mem_address    = (sel == M1) ? m1_address    : m0_address;
   assign mem_byteenable = (sel == M1) ? m1_byteenable : m0_byteenable;
   assign mem_writedata  = (sel == M1) ? m1_writedata  : m0_writedata;
   assign mem_chipselect = |grant;
   assign mem_write      = (grant[0] & m0_write) | (grant[1] & m1_write);
   assign mem_clken      = 1'b1;

   assign rd_accept = (grant[0] & is_read_only(m0_read, m0_write))
                    | (grant[1] & is_read_only(m1_read, m1_write));

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pending <= 1'b0;
         rd_tag     <= M0;
      end else begin
         rd_pending <= rd_accept;
         if (rd_accept) begin
            rd_tag <= sel;
         end
      end
   end

   // Gating with reset kills the return of a read accepted just before reset asserts.
   assign m0_readdatavalid = rd_pending & ~reset & (rd_tag == M0);
   assign m1_readdatavalid = rd_pending & ~reset & (rd_tag == M1);

   assign m0_readdata = mem_readdata;
   assign m1_readdata = mem_readdata;

endmodule
